// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and opcode constants for the ALU arbiter
//
// Purpose : FSM state type and ALUControl opcode encodings shared by
//           alu_arbiter and its grant logic.
// Contents: state_t {IDLE, EXEC, RESP}; OP_ADD..OP_ASR (0..9); OP_MAX.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ASL = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;

  // Highest opcode the ALU implements; anything above is answered with an error.
  localparam logic [3:0] OP_MAX = OP_ASR;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-input grant logic for the ALU arbiter
//
// Purpose : Produces a one-hot grant for two requesters. A lone requester
//           always wins; on a tie the port that did not win last time wins.
//           With ALU_ARB_FIXED_PRIO_EN defined, port 0 always wins a tie
//           and last_grant is ignored.
// Ports   : req[1:0]   request lines (bit i = port i)
//           last_grant port that won the previous handshake
//           en         grant enable; gnt is all-zero when low
//           gnt[1:0]   one-hot grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
        2'b11:   gnt = 2'b01;
`else
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
`endif
        default: gnt = 2'b00;
      endcase
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational N-bit ALU between two requesters
//
// Purpose : Arbitrates two request ports onto one ALU, registers the winning
//           operands/opcode onto the ALU inputs, captures result and flags,
//           and returns them to the winner with a one-cycle rsp_valid pulse.
//           Handshake at edge t -> rsp_valid high in the cycle after edge t+2.
// Config  : ALU_ARB_FIXED_PRIO_EN - port 0 always wins ties (no last_grant).
// Ports   : clk, rst (async, active-high)
//           reqX_valid/reqX_ready/reqX_op/reqX_a/reqX_b  request port X (0,1)
//           rsp_valid[1:0] one-hot response pulse, rsp_result, rsp_flags
//           (VZCN), rsp_err (illegal opcode)
//           alu_a, alu_b, alu_ctrl  registered ALU inputs
//           alu_result, alu_flags   ALU outputs
//           busy                    state != IDLE
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [1:0]   rsp_valid,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         busy
);

  state_t       state_q, state_d;
  logic [1:0]   gnt;
  logic         handshake;
  logic         sel_port;
  logic [3:0]   sel_op;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_illegal;
  logic         owner_q;
  logic         err_q;
  logic         last_grant_w;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_w),
    .en         (state_q == IDLE),
    .gnt        (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  // The arbiter only grants a valid port, so any grant is a handshake.
  assign handshake  = |gnt;
  assign sel_port   = gnt[1];
  assign busy       = (state_q != IDLE);

  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (sel_port) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  assign sel_illegal = (sel_op > OP_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign last_grant_w = 1'b0;
`else
  logic last_grant_q;

  // Reset to 1 so port 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (handshake) begin
      last_grant_q <= sel_port;
    end
  end

  assign last_grant_w = last_grant_q;
`endif

  // Issue registers double as the ALU input registers. Illegal opcodes are
  // replaced by all-zero inputs so the ALU never sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (handshake) begin
      owner_q  <= sel_port;
      err_q    <= sel_illegal;
      alu_a    <= sel_illegal ? '0 : sel_a;
      alu_b    <= sel_illegal ? '0 : sel_b;
      alu_ctrl <= sel_illegal ? 4'd0 : sel_op;
    end
  end

  // Result is captured at the end of EXEC; the valid pulse is registered out
  // of RESP so it appears in the cycle after the third edge from handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      if (state_q == EXEC) begin
        rsp_result <= err_q ? '0 : alu_result;
        rsp_flags  <= err_q ? 4'd0 : alu_flags;
      end
      if (state_q == RESP) begin
        rsp_valid <= owner_q ? 2'b10 : 2'b01;
        rsp_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   rsp_valid;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for ALU_N_Bits; flags are {V, Z, C, N}.
  logic [N:0] ext;
  logic       ovf;
  always_comb begin
    ext = '0;
    ovf = 1'b0;
    case (alu_ctrl)
      4'd0: ext = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: ext = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      4'd2: ext = {1'b0, alu_a & alu_b};
      4'd3: ext = {1'b0, alu_a | alu_b};
      4'd4: ext = {1'b0, ~alu_a};
      4'd5: ext = {1'b0, alu_a ^ alu_b};
      4'd6: ext = {1'b0, alu_a << alu_b[1:0]};
      4'd7: ext = {1'b0, alu_a >> alu_b[1:0]};
      4'd8: ext = {1'b0, alu_a << alu_b[1:0]};
      4'd9: ext = {1'b0, $signed(alu_a) >>> alu_b[1:0]};
      default: ext = '0;
    endcase
    if (alu_ctrl == 4'd0)
      ovf = (alu_a[N-1] == alu_b[N-1]) && (ext[N-1] != alu_a[N-1]);
    else if (alu_ctrl == 4'd1)
      ovf = (alu_a[N-1] != alu_b[N-1]) && (ext[N-1] != alu_a[N-1]);
    alu_result = ext[N-1:0];
    alu_flags  = {ovf, (ext[N-1:0] == '0), (alu_ctrl <= 4'd1) ? ext[N] : 1'b0, ext[N-1]};
  end

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b r=%h f=%b e=%b want all 0", rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_alu got a=%h b=%h c=%h busy=%b want all 0", alu_a, alu_b, alu_ctrl, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_add_port0();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd3; req0_b = 4'd4;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ready got %b want 1", req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({busy, alu_a, alu_b, alu_ctrl, rsp_valid} !== {1'b1, 4'd3, 4'd4, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL add_exec got busy=%b a=%h b=%h c=%h v=%b want 1 3 4 0 00", busy, alu_a, alu_b, alu_ctrl, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, req0_ready} !== 3'b000) begin
      errors++;
      $display("FAIL add_resp_early got v=%b rdy=%b want 00 0", rsp_valid, req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== {2'b01, 4'd7, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp got v=%b r=%h f=%b e=%b want 01 7 0000 0", rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL add_pulse_width got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_sub_port1();
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'd2; req1_b = 4'd5;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL sub_ready got %b want 10", {req1_ready, req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== {2'b10, 4'hD, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL sub_rsp got v=%b r=%h f=%b e=%b want 10 d 0001 0", rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_gnt;
    logic [N-1:0] exp_res;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 4'd5; req1_b = 4'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_gnt = 2'b01;
`else
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_res = (exp_gnt == 2'b01) ? 4'd2 : 4'd7;
      checks++;
      if ({req1_ready, req0_ready} !== exp_gnt) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b want %b", k, {req1_ready, req0_ready}, exp_gnt);
      end
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_result} !== {exp_gnt, exp_res}) begin
        errors++;
        $display("FAIL rr_rsp[%0d] got v=%b r=%h want %b %h", k, rsp_valid, rsp_result, exp_gnt, exp_res);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_illegal_op();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'hC; req0_a = 4'd5; req0_b = 4'd6;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL ill_ready got %b want 1", req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 12'd0) begin
      errors++;
      $display("FAIL ill_alu_exec got a=%h b=%h c=%h want 0 0 0", alu_a, alu_b, alu_ctrl);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (alu_ctrl !== 4'd0) begin
      errors++;
      $display("FAIL ill_alu_resp got %h want 0", alu_ctrl);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_err, alu_ctrl} !== {2'b01, 4'd0, 4'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL ill_rsp got v=%b r=%h f=%b e=%b c=%h want 01 0 0000 1 0", rsp_valid, rsp_result, rsp_flags, rsp_err, alu_ctrl);
    end
  endtask

  task automatic test_reset_mid_op();
    logic saw_pulse;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({busy, alu_a} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL rmo_exec got busy=%b a=%h want 1 1", busy, alu_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_flags, rsp_err} !== 24'd0) begin
      errors++;
      $display("FAIL rmo_async got busy=%b a=%h b=%h c=%h v=%b r=%h f=%b e=%b want all 0",
               busy, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) saw_pulse = 1'b1;
    end
    checks++;
    if (saw_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rmo_no_pulse got pulse=%b want 0", saw_pulse);
    end
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 4'd0; req1_b = 4'd0;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_err} !== {2'b10, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL rmo_not got v=%b r=%h e=%b want 10 f 0", rsp_valid, rsp_result, rsp_err);
    end
  endtask

  task automatic test_late_port0();
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = 4'd1; req1_b = 4'd1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_p1_ready got %b want 1", req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req1_op = 4'd3; req1_a = 4'd5; req1_b = 4'd2;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd3; req0_b = 4'd4;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL late_exec_ready got %b want 00", {req1_ready, req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL late_resp_ready got %b want 00", {req1_ready, req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_result, req1_ready, req0_ready} !== {2'b10, 4'd2, 2'b01}) begin
      errors++;
      $display("FAIL late_grant got v=%b r=%h rdy=%b want 10 2 01", rsp_valid, rsp_result, {req1_ready, req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result} !== {2'b01, 4'd7}) begin
      errors++;
      $display("FAIL late_p0_rsp got v=%b r=%h want 01 7", rsp_valid, rsp_result);
    end
  endtask

  initial begin
    test_reset();
    test_add_port0();
    test_sub_port1();
    test_round_robin();
    test_illegal_op();
    test_reset_mid_op();
    test_late_port0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
